// File: rtl/pixel_coord_generator.sv
// Raster-scan pixel coordinate source for the ray generator.
// Issue is throttled by a credit counter, because the consumer cannot stall us;
// downstream returns one pixel_done per completed pixel to release a credit.
`ifndef SCREEN_WIDTH
`define SCREEN_WIDTH 640
`endif
`ifndef SCREEN_HEIGHT
`define SCREEN_HEIGHT 480
`endif

module pixel_coord_generator #(
  parameter int SCREEN_WIDTH  = `SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = `SCREEN_HEIGHT,
  parameter int MAX_IN_FLIGHT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pixel_done,
  output logic [31:0] screen_x,
  output logic [31:0] screen_y,
  output logic        coords_valid,
  output logic        sof,
  output logic        eol,
  output logic        busy,
  output logic        frame_done,
  output logic        err_underflow
);

  localparam int XW = (SCREEN_WIDTH  > 1) ? $clog2(SCREEN_WIDTH)  : 1;
  localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
  localparam int OW = $clog2(MAX_IN_FLIGHT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [OW-1:0] outs_q, outs_d;
  logic [31:0]   sx_q, sx_d, sy_q, sy_d;
  logic          valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
  logic          busy_q, busy_d, fd_q, fd_d, err_q, err_d;
  logic          issue, x_last, y_last;

  // Next-state: issue decision, raster counters, credit accounting and FSM.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    outs_d  = outs_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eol_d   = 1'b0;
    fd_d    = 1'b0;
    err_d   = err_q;

    // Registered credit count only: a same-cycle pixel_done does not free a slot.
    issue  = (state_q == S_RUN) && (outs_q < OW'(MAX_IN_FLIGHT));
    x_last = (x_q == XW'(SCREEN_WIDTH - 1));
    y_last = (y_q == YW'(SCREEN_HEIGHT - 1));

    if (issue) begin
      valid_d = 1'b1;
      sx_d    = 32'(x_q);
      sy_d    = 32'(y_q);
      sof_d   = (x_q == '0) && (y_q == '0);
      eol_d   = x_last;
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    // Issue and return in the same cycle cancel; a return with nothing out is an error.
    case ({issue, pixel_done})
      2'b10:   outs_d = outs_q + OW'(1);
      2'b01: begin
        if (outs_q != '0) outs_d = outs_q - OW'(1);
        else              err_d  = 1'b1;
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_RUN: begin
        if (issue && x_last && y_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (outs_d == '0) begin
          state_d = S_IDLE;
          fd_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; synchronous active-low reset abandons any frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      outs_q  <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      outs_q  <= outs_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign screen_x      = sx_q;
  assign screen_y      = sy_q;
  assign coords_valid  = valid_q;
  assign sof           = sof_q;
  assign eol           = eol_q;
  assign busy          = busy_q;
  assign frame_done    = fd_q;
  assign err_underflow = err_q;

endmodule
